pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised inter-stage pipeline register; next generation of the fixed ID/EX latch.
//  Carries an opaque DATA_W payload with a valid bit and delay-slot tracking.
//  Resolves reset, flush, bubble, load and hold from the global stall vector.
//  Keeps saturating bubble and hold counters for stall profiling.
//  Instanced between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB) of the 5-stage core.
// PARAMETERS
//  DATA_W       64      payload width (packed aluOp/aluSel/operands/wd/wreg/link addr)
//  STALL_W      6       width of global stall vector
//  STAGE        2       index of the upstream stage in stall[]; STAGE+1 <= STALL_W-1
//  NOP_PAYLOAD  '0      payload value driven on bubble, flush and reset
//  CNT_W        16      width of the profiling counters
// PORTS
//  clk                      in   1        core clock, rising edge
//  rst                      in   1        synchronous reset, active-high (`RstEnable)
//  stall                    in   STALL_W  global stall vector (`Stop = 1)
//  flush                    in   1        exception/redirect flush, active-high
//  cnt_clr                  in   1        synchronous clear of both counters
//  in_valid                 in   1        upstream slot holds a real instruction
//  in_data                  in   DATA_W   upstream payload
//  in_is_in_delayslot       in   1        upstream instruction sits in a delay slot
//  next_inst_in_delayslot_i in   1        branch in upstream marks following inst as delay slot
//  out_valid                out  1        downstream slot valid
//  out_data                 out  DATA_W   registered payload
//  out_is_in_delayslot      out  1        registered delay-slot flag
//  is_in_delayslot_o        out  1        registered next-delay-slot flag, returned upstream
//  bubble_cnt               out  CNT_W    bubbles inserted since clear
//  hold_cnt                 out  CNT_W    hold cycles since clear
// BEHAVIOUR
//  All outputs are registered; latency is 1 cycle on load. Per clock edge, first match wins:
//  1 rst: out_valid=0, out_data=NOP_PAYLOAD, both delay-slot flags=`NotInDelaySlot (0);
//    bubble_cnt=0, hold_cnt=0.
//  2 flush: same clears as rst for out_valid/out_data/both flags; counters are untouched.
//    Flush overrides any stall.
//  3 BUBBLE, stall[STAGE]=1 and stall[STAGE+1]=0:
//    - out_valid=0, out_data=NOP_PAYLOAD, out_is_in_delayslot=0.
//    - is_in_delayslot_o is HELD, so a branch stalled in upstream keeps its delay-slot mark.
//    - bubble_cnt+1.
//  4 LOAD, stall[STAGE]=0:
//    - out_valid<=in_valid, out_data<=in_data, out_is_in_delayslot<=in_is_in_delayslot.
//    - is_in_delayslot_o<=next_inst_in_delayslot_i.
//    - Payload loads even when in_valid=0; consumers must qualify with out_valid.
//  5 HOLD, stall[STAGE]=1 and stall[STAGE+1]=1: all outputs keep value; hold_cnt+1.
//  Counters:
//    - Saturate at all-ones; no wrap.
//    - cnt_clr zeroes both; it has priority over increment in the same cycle.
//    - cnt_clr has lower priority than rst.
//  Stall bits outside STAGE/STAGE+1 are ignored.
//  X on in_* during BUBBLE/HOLD never reaches outputs.
//  Reset asserted mid-stall: rst wins. The first cycle after reset follows rule 3/4/5 normally.
//  Elaboration check: STAGE+1 >= STALL_W is a fatal $error.
// STRUCTURE
//  Shared package / defines.v holds `RstEnable, `Stop/`NoStop, `NotInDelaySlot and `ZeroWord.
//  Per-stage payload structs (id_ex_payload_t, ...) and their NOP constants go in a core_pkg.
//  Sub-module sat_counter #(CNT_W) (clk, rst, clr, inc, q) is instanced twice, for bubble and hold.
//  The remainder is one always block implementing the priority chain above.
// TESTING
//  T1 rst=1 for 2 cycles, all in_*=1 -> out_valid=0, out_data=NOP_PAYLOAD, flags=0, counters=0.
//  T2 stall=6'b000000, in_data=64'hDEAD_BEEF_0000_0001, in_valid=1 -> out_data equals it one
//     cycle later, out_valid=1.
//  T3 stall=6'b000111 (STAGE=2) for 3 cycles with is_in_delayslot_o=1 beforehand ->
//     out_valid=0, out_data=NOP_PAYLOAD, is_in_delayslot_o stays 1, bubble_cnt=3.
//  T4 stall=6'b001111 for 4 cycles after a load of 64'h1234 -> out_data stays 64'h1234,
//     hold_cnt=4, bubble_cnt unchanged.
//  T5 flush=1 together with stall=6'b001111 -> outputs cleared next cycle, counters unchanged;
//     flush with rst=1 -> counters also 0.
//  T6 CNT_W=4, 20 bubble cycles -> bubble_cnt saturates at 4'hF; cnt_clr and bubble in the
//     same cycle -> 0.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants and stage-action decode for the inter-stage pipeline register.
// Latency: n/a (package only).
// Backpressure: n/a; the stall vector is decoded by resolve_act().
package pipe_stage_reg_pkg;

    localparam logic RST_ENABLE        = 1'b1;  // reset asserted level
    localparam logic STOP              = 1'b1;  // stall bit level meaning "stage stopped"
    localparam logic NOT_IN_DELAY_SLOT = 1'b0;  // delay-slot flag cleared value

    // What the register does on the coming clock edge.
    typedef enum logic [2:0] {
        ACT_RESET  = 3'd0,
        ACT_FLUSH  = 3'd1,
        ACT_BUBBLE = 3'd2,
        ACT_LOAD   = 3'd3,
        ACT_HOLD   = 3'd4
    } stage_act_e;

    // First match wins: reset, flush, then the upstream/downstream stall pair.
    // Upstream stopped while downstream runs means a bubble must be injected;
    // both stopped means the slot simply holds.
    function automatic stage_act_e resolve_act(
        input logic rst,
        input logic flush,
        input logic up_stall,
        input logic dn_stall
    );
        if (rst == RST_ENABLE)    return ACT_RESET;
        else if (flush)           return ACT_FLUSH;
        else if (up_stall != STOP) return ACT_LOAD;
        else if (dn_stall != STOP) return ACT_BUBBLE;
        else                      return ACT_HOLD;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter for stall profiling: sticks at all-ones instead of wrapping.
// Latency: 1 cycle from inc/clr to q.
// Backpressure: none; rst beats clr, clr beats inc.
// Ports: clk, rst (sync, active-high), clr (sync clear), inc (count enable), q (count).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != '1)) begin
            r_q <= r_q + ONE;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid, delay-slot tracking and bubble/hold profiling counters.
// Latency: 1 cycle on load; all outputs registered.
// Backpressure: stall[STAGE]/stall[STAGE+1] select load, bubble or hold; flush and rst override stall.
// Ports:
//   clk, rst (sync active-high), stall[STALL_W], flush, cnt_clr
//   in_valid, in_data, in_is_in_delayslot, next_inst_in_delayslot_i  (from upstream stage)
//   out_valid, out_data, out_is_in_delayslot                           (to downstream stage)
//   is_in_delayslot_o  (next-delay-slot flag returned upstream)
//   bubble_cnt, hold_cnt  (saturating profiling counters)
module pipe_stage_reg #(
    parameter int                DATA_W      = 64,
    parameter int                STALL_W     = 6,
    parameter int                STAGE       = 2,
    parameter logic [DATA_W-1:0] NOP_PAYLOAD = '0,
    parameter int                CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               cnt_clr,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_is_in_delayslot,
    input  logic               next_inst_in_delayslot_i,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_is_in_delayslot,
    output logic               is_in_delayslot_o,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   hold_cnt
);

    import pipe_stage_reg_pkg::*;

    // The downstream stall bit must exist in the vector.
    if (STAGE + 1 >= STALL_W) begin : g_bad_stage
        $error("pipe_stage_reg: STAGE+1 (%0d) must be below STALL_W (%0d)", STAGE + 1, STALL_W);
    end

    stage_act_e        w_act;
    logic              w_bubble_inc;
    logic              w_hold_inc;
    logic              w_unused_stall;

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_ds;
    logic              r_next_ds;

    assign w_act        = resolve_act(rst, flush, stall[STAGE], stall[STAGE+1]);
    assign w_bubble_inc = (w_act == ACT_BUBBLE);
    assign w_hold_inc   = (w_act == ACT_HOLD);

    // Only two stall bits matter here; the rest of the vector belongs to other stages.
    assign w_unused_stall = ^stall;

    always_ff @(posedge clk) begin
        case (w_act)
            ACT_RESET, ACT_FLUSH: begin
                r_valid   <= 1'b0;
                r_data    <= NOP_PAYLOAD;
                r_ds      <= NOT_IN_DELAY_SLOT;
                r_next_ds <= NOT_IN_DELAY_SLOT;
            end
            ACT_BUBBLE: begin
                // r_next_ds is held: a branch stalled upstream must keep marking
                // its delay slot once it finally advances.
                r_valid <= 1'b0;
                r_data  <= NOP_PAYLOAD;
                r_ds    <= NOT_IN_DELAY_SLOT;
            end
            ACT_LOAD: begin
                // Payload loads regardless of in_valid; consumers qualify with out_valid.
                r_valid   <= in_valid;
                r_data    <= in_data;
                r_ds      <= in_is_in_delayslot;
                r_next_ds <= next_inst_in_delayslot_i;
            end
            default: begin
                // ACT_HOLD: every output keeps its value.
            end
        endcase
    end

    assign out_valid           = r_valid;
    assign out_data            = r_data;
    assign out_is_in_delayslot = r_ds;
    assign is_in_delayslot_o   = r_next_ds;

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (w_bubble_inc),
        .q   (bubble_cnt)
    );

    sat_counter #(.W(CNT_W)) u_hold_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (w_hold_inc),
        .q   (hold_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a 16-bit-counter instance and a 4-bit-counter instance share stimulus.
// Stimulus pushes predicted post-edge state into a queue; a monitor pops and compares after each edge.
// Directed scenarios first, then randomized stall/flush/reset/clear traffic.
module tb_pipe_stage_reg;

    localparam int DATA_W  = 64;
    localparam int STALL_W = 6;
    localparam int STAGE   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic               cnt_clr;
    logic               in_valid;
    logic [DATA_W-1:0]  in_data;
    logic               in_is_in_delayslot;
    logic               next_inst_in_delayslot_i;

    logic               out_valid;
    logic [DATA_W-1:0]  out_data;
    logic               out_is_in_delayslot;
    logic               is_in_delayslot_o;
    logic [15:0]        bubble_cnt;
    logic [15:0]        hold_cnt;

    logic               s_out_valid;
    logic [DATA_W-1:0]  s_out_data;
    logic               s_out_is_in_delayslot;
    logic               s_is_in_delayslot_o;
    logic [3:0]         s_bubble_cnt;
    logic [3:0]         s_hold_cnt;

    pipe_stage_reg #(.DATA_W(DATA_W), .STALL_W(STALL_W), .STAGE(STAGE), .CNT_W(16)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .stall                    (stall),
        .flush                    (flush),
        .cnt_clr                  (cnt_clr),
        .in_valid                 (in_valid),
        .in_data                  (in_data),
        .in_is_in_delayslot       (in_is_in_delayslot),
        .next_inst_in_delayslot_i (next_inst_in_delayslot_i),
        .out_valid                (out_valid),
        .out_data                 (out_data),
        .out_is_in_delayslot      (out_is_in_delayslot),
        .is_in_delayslot_o        (is_in_delayslot_o),
        .bubble_cnt               (bubble_cnt),
        .hold_cnt                 (hold_cnt)
    );

    pipe_stage_reg #(.DATA_W(DATA_W), .STALL_W(STALL_W), .STAGE(STAGE), .CNT_W(4)) dut_small (
        .clk                      (clk),
        .rst                      (rst),
        .stall                    (stall),
        .flush                    (flush),
        .cnt_clr                  (cnt_clr),
        .in_valid                 (in_valid),
        .in_data                  (in_data),
        .in_is_in_delayslot       (in_is_in_delayslot),
        .next_inst_in_delayslot_i (next_inst_in_delayslot_i),
        .out_valid                (s_out_valid),
        .out_data                 (s_out_data),
        .out_is_in_delayslot      (s_out_is_in_delayslot),
        .is_in_delayslot_o        (s_is_in_delayslot_o),
        .bubble_cnt               (s_bubble_cnt),
        .hold_cnt                 (s_hold_cnt)
    );

    typedef struct {
        logic              v;
        logic [DATA_W-1:0] d;
        logic              ds;
        logic              nds;
        int                bub;
        int                hold;
        int                bub4;
        int                hold4;
    } exp_t;

    exp_t m;          // reference state after the most recently issued edge
    exp_t sb_q[$];    // predictions awaiting comparison

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic int sat_inc(input int v, input int max);
        return (v < max) ? v + 1 : v;
    endfunction

    // Apply one cycle of inputs and predict what the outputs look like after the edge.
    task automatic step(input logic r, input logic f, input logic c, input logic [STALL_W-1:0] s,
                        input logic v, input logic [DATA_W-1:0] d, input logic ds, input logic nds);
        logic up;
        logic dn;
        @(negedge clk);
        rst = r; flush = f; cnt_clr = c; stall = s;
        in_valid = v; in_data = d; in_is_in_delayslot = ds; next_inst_in_delayslot_i = nds;
        up = s[STAGE];
        dn = s[STAGE+1];
        if (r || f) begin
            m.v = 1'b0; m.d = '0; m.ds = 1'b0; m.nds = 1'b0;
        end else if (!up) begin
            m.v = v; m.d = d; m.ds = ds; m.nds = nds;
        end else if (!dn) begin
            m.v = 1'b0; m.d = '0; m.ds = 1'b0;
        end
        if (r || c) begin
            m.bub = 0; m.hold = 0; m.bub4 = 0; m.hold4 = 0;
        end else if (!f && up && !dn) begin
            m.bub  = sat_inc(m.bub, 65535);
            m.bub4 = sat_inc(m.bub4, 15);
        end else if (!f && up && dn) begin
            m.hold  = sat_inc(m.hold, 65535);
            m.hold4 = sat_inc(m.hold4, 15);
        end
        sb_q.push_back(m);
    endtask

    function automatic logic [DATA_W-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Monitor: outputs are registered, so every edge presents a new slot state.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("out_valid",           64'(out_valid),           64'(e.v));
                chk("out_data",            out_data,                 e.d);
                chk("out_is_in_delayslot", 64'(out_is_in_delayslot), 64'(e.ds));
                chk("is_in_delayslot_o",   64'(is_in_delayslot_o),   64'(e.nds));
                chk("bubble_cnt",          64'(bubble_cnt),          64'(e.bub));
                chk("hold_cnt",            64'(hold_cnt),            64'(e.hold));
                chk("bubble_cnt_w4",       64'(s_bubble_cnt),        64'(e.bub4));
                chk("hold_cnt_w4",         64'(s_hold_cnt),          64'(e.hold4));
                chk("out_data_w4",         s_out_data,               e.d);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog at %0t: bench did not complete", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic r, f, c;
        rst = 1'b1; flush = 1'b0; cnt_clr = 1'b0; stall = '0;
        in_valid = 1'b0; in_data = '0; in_is_in_delayslot = 1'b0; next_inst_in_delayslot_i = 1'b0;
        m = '{v: 1'b0, d: '0, ds: 1'b0, nds: 1'b0, bub: 0, hold: 0, bub4: 0, hold4: 0};

        // Reset with every input driven high.
        repeat (2) step(1'b1, 1'b0, 1'b1, '1, 1'b1, '1, 1'b1, 1'b1);

        // Plain load.
        step(1'b0, 1'b0, 1'b0, 6'b000000, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0);

        // Branch loads with next-delay-slot set, then three bubbles keep that mark.
        step(1'b0, 1'b0, 1'b0, 6'b000000, 1'b1, 64'h0000_0000_0000_0055, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b0, 6'b000111, 1'b1, rnd64(), 1'b1, 1'b0);

        // Load then four hold cycles; payload must not move.
        step(1'b0, 1'b0, 1'b0, 6'b000000, 1'b1, 64'h1234, 1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b0, 1'b0, 6'b001111, 1'b1, rnd64(), 1'b0, 1'b0);

        // Flush beats hold; flush with reset also clears the counters.
        step(1'b0, 1'b1, 1'b0, 6'b001111, 1'b1, rnd64(), 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 6'b001111, 1'b1, rnd64(), 1'b1, 1'b1);

        // Twenty bubbles saturate the 4-bit counter; clear wins over a same-cycle bubble.
        repeat (20) step(1'b0, 1'b0, 1'b0, 6'b000100, 1'b1, rnd64(), 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 6'b000100, 1'b1, rnd64(), 1'b1, 1'b1);

        // Ignored stall bits toggling around a load.
        step(1'b0, 1'b0, 1'b0, 6'b110011, 1'b1, 64'hCAFE_F00D_1357_9BDF, 1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 31) == 0);
            f = ($urandom_range(0, 15) == 0);
            c = ($urandom_range(0, 15) == 0);
            step(r, f, c, 6'($urandom_range(0, 63)), 1'($urandom), rnd64(), 1'($urandom), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
